// File: rtl/mod_n_stream_detector.sv
// Multi-channel MSB-first serial divisibility detector: per-channel n mod DIVISOR,
// divisible flag and saturating divisible-event counter.
module mod_n_stream_detector #(
    parameter int DIVISOR  = 5,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int ZERO_HIT = 0,
    localparam int REM_W   = ($clog2(DIVISOR) > 1) ? $clog2(DIVISOR) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS-1:0]       in_bit,
    input  logic [CHANNELS-1:0]       in_clear,
    input  logic [CHANNELS-1:0]       cnt_clr,
    output logic [CHANNELS-1:0]       div_hit,
    output logic [CHANNELS*REM_W-1:0] remainder,
    output logic [CHANNELS*CNT_W-1:0] hit_count,
    output logic [CHANNELS-1:0]       cnt_sat
);

    localparam logic [REM_W:0]   DIV_T   = (REM_W + 1)'(DIVISOR);
    localparam logic [REM_W-1:0] DIV_R   = REM_W'(DIVISOR);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [REM_W-1:0] rem;
        logic [REM_W-1:0] rem_nx;
        logic [REM_W:0]   t;
        logic             qual;
        logic             qual_nx;
        logic             hit_ev;
        logic [CNT_W-1:0] cnt;
        logic             sat;

        // rem < DIVISOR, so one conditional subtract reduces 2*rem+bit;
        // the low REM_W bits of the difference are exact even when DIVISOR is 2^REM_W.
        always_comb begin
            t       = {rem, in_bit[c]};
            rem_nx  = (t >= DIV_T) ? (t[REM_W-1:0] - DIV_R) : t[REM_W-1:0];
            qual_nx = (ZERO_HIT != 0) ? 1'b1 : (qual | in_bit[c]);
            hit_ev  = in_valid[c] && !in_clear[c] && (rem_nx == '0) && qual_nx;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rem  <= '0;
                qual <= 1'b0;
                cnt  <= '0;
                sat  <= 1'b0;
            end else begin
                if (in_clear[c]) begin
                    rem  <= '0;
                    qual <= 1'b0;
                end else if (in_valid[c]) begin
                    rem  <= rem_nx;
                    qual <= qual_nx;
                end

                // A clear on the same edge as a hit event drops that event.
                if (cnt_clr[c]) begin
                    cnt <= '0;
                    sat <= 1'b0;
                end else if (hit_ev && (cnt != CNT_MAX)) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_MAX - 1'b1) begin
                        sat <= 1'b1;
                    end
                end
            end
        end

`ifndef SYNTHESIS
        always_ff @(posedge clk) begin
            if (rst_n) begin
                assert ({1'b0, rem} < DIV_T);
            end
        end
`endif

        assign div_hit[c]                     = (rem == '0) && qual;
        assign remainder[c*REM_W +: REM_W]    = rem;
        assign hit_count[c*CNT_W +: CNT_W]    = cnt;
        assign cnt_sat[c]                     = sat;
    end

endmodule

// File: tb/tb_mod_n_stream_detector.sv
// Directed bench for mod_n_stream_detector across several parameter sets.
module tb_mod_n_stream_detector;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // DIVISOR=5, one channel
    logic        a_v = 0, a_b = 0, a_clr = 0, a_cclr = 0;
    logic        a_hit, a_sat;
    logic [2:0]  a_rem;
    logic [15:0] a_cnt;

    // DIVISOR=7, ZERO_HIT=0 and ZERO_HIT=1 fed identically
    logic        z_v = 0, z_b = 0, z_zero = 0;
    logic        z0_hit, z0_sat, z1_hit, z1_sat;
    logic [2:0]  z0_rem, z1_rem;
    logic [15:0] z0_cnt, z1_cnt;

    // DIVISOR=3, CNT_W=2
    logic        s_v = 0, s_b = 0, s_clr = 0, s_cclr = 0;
    logic        s_hit, s_sat;
    logic [1:0]  s_rem;
    logic [1:0]  s_cnt;

    // DIVISOR=2, four channels
    logic [3:0]  m_v = '0, m_b = '0, m_clr = '0, m_cclr = '0;
    logic [3:0]  m_hit, m_sat, m_rem;
    logic [63:0] m_cnt;

    mod_n_stream_detector #(.DIVISOR(5), .CHANNELS(1), .CNT_W(16), .ZERO_HIT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_v), .in_bit(a_b), .in_clear(a_clr),
        .cnt_clr(a_cclr), .div_hit(a_hit), .remainder(a_rem), .hit_count(a_cnt), .cnt_sat(a_sat));

    mod_n_stream_detector #(.DIVISOR(7), .CHANNELS(1), .CNT_W(16), .ZERO_HIT(0)) u_z0 (
        .clk(clk), .rst_n(rst_n), .in_valid(z_v), .in_bit(z_b), .in_clear(z_zero),
        .cnt_clr(z_zero), .div_hit(z0_hit), .remainder(z0_rem), .hit_count(z0_cnt), .cnt_sat(z0_sat));

    mod_n_stream_detector #(.DIVISOR(7), .CHANNELS(1), .CNT_W(16), .ZERO_HIT(1)) u_z1 (
        .clk(clk), .rst_n(rst_n), .in_valid(z_v), .in_bit(z_b), .in_clear(z_zero),
        .cnt_clr(z_zero), .div_hit(z1_hit), .remainder(z1_rem), .hit_count(z1_cnt), .cnt_sat(z1_sat));

    mod_n_stream_detector #(.DIVISOR(3), .CHANNELS(1), .CNT_W(2), .ZERO_HIT(0)) u_s (
        .clk(clk), .rst_n(rst_n), .in_valid(s_v), .in_bit(s_b), .in_clear(s_clr),
        .cnt_clr(s_cclr), .div_hit(s_hit), .remainder(s_rem), .hit_count(s_cnt), .cnt_sat(s_sat));

    mod_n_stream_detector #(.DIVISOR(2), .CHANNELS(4), .CNT_W(16), .ZERO_HIT(0)) u_m (
        .clk(clk), .rst_n(rst_n), .in_valid(m_v), .in_bit(m_b), .in_clear(m_clr),
        .cnt_clr(m_cclr), .div_hit(m_hit), .remainder(m_rem), .hit_count(m_cnt), .cnt_sat(m_sat));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_v = 1'b1; a_b = 1'b1;
        m_v = 4'hF; m_b = 4'hF;
        tick();
        tick();
        checks++;
        if ({a_hit, a_rem, a_cnt, a_sat} !== '0) begin
            $display("FAIL reset_div5 got hit=%0b rem=%0d cnt=%0d sat=%0b exp all 0", a_hit, a_rem, a_cnt, a_sat);
            failures++;
        end
        checks++;
        if ({z0_hit, z1_hit, z0_rem, z1_rem, z0_cnt, z1_cnt, z0_sat, z1_sat} !== '0) begin
            $display("FAIL reset_div7 got hit0=%0b hit1=%0b cnt1=%0d exp all 0", z0_hit, z1_hit, z1_cnt);
            failures++;
        end
        checks++;
        if ({m_hit, m_rem, m_cnt, m_sat, s_hit, s_rem, s_cnt, s_sat} !== '0) begin
            $display("FAIL reset_multi got hit=%b rem=%b cnt=%h sat=%b exp all 0", m_hit, m_rem, m_cnt, m_sat);
            failures++;
        end
        a_v = 1'b0; a_b = 1'b0;
        m_v = 4'h0; m_b = 4'h0;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic       bits    [3] = '{1'b1, 1'b0, 1'b1};
        logic [2:0] exp_rem [3] = '{3'd1, 3'd2, 3'd0};
        logic       exp_hit [3] = '{1'b0, 1'b0, 1'b1};
        logic [15:0] exp_cnt [3] = '{16'd0, 16'd0, 16'd1};
        for (int i = 0; i < 3; i++) begin
            a_v = 1'b1; a_b = bits[i];
            tick();
            checks++;
            if (a_rem !== exp_rem[i] || a_hit !== exp_hit[i] || a_cnt !== exp_cnt[i]) begin
                $display("FAIL basic_step%0d got rem=%0d hit=%0b cnt=%0d exp rem=%0d hit=%0b cnt=%0d",
                         i, a_rem, a_hit, a_cnt, exp_rem[i], exp_hit[i], exp_cnt[i]);
                failures++;
            end
        end
        a_v = 1'b0;
    endtask

    task automatic test_gap();
        a_clr = 1'b1; a_cclr = 1'b1;
        tick();
        a_clr = 1'b0; a_cclr = 1'b0;
        checks++;
        if (a_rem !== 3'd0 || a_hit !== 1'b0 || a_cnt !== 16'd0 || a_sat !== 1'b0) begin
            $display("FAIL gap_clear got rem=%0d hit=%0b cnt=%0d exp 0 0 0", a_rem, a_hit, a_cnt);
            failures++;
        end
        a_v = 1'b1; a_b = 1'b1; tick();
        a_b = 1'b0; tick();
        a_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (a_rem !== 3'd2 || a_hit !== 1'b0) begin
                $display("FAIL gap_hold%0d got rem=%0d hit=%0b exp rem=2 hit=0", i, a_rem, a_hit);
                failures++;
            end
        end
        a_v = 1'b1; a_b = 1'b1; tick();
        checks++;
        if (a_rem !== 3'd0 || a_hit !== 1'b1 || a_cnt !== 16'd1) begin
            $display("FAIL gap_resume got rem=%0d hit=%0b cnt=%0d exp rem=0 hit=1 cnt=1", a_rem, a_hit, a_cnt);
            failures++;
        end
        a_b = 1'b0; tick();
        a_v = 1'b0;
        checks++;
        if (a_rem !== 3'd0 || a_hit !== 1'b1 || a_cnt !== 16'd2) begin
            $display("FAIL gap_zero_run got rem=%0d hit=%0b cnt=%0d exp rem=0 hit=1 cnt=2", a_rem, a_hit, a_cnt);
            failures++;
        end
    endtask

    task automatic test_simultaneous();
        a_v = 1'b1; a_b = 1'b1; a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        checks++;
        if (a_rem !== 3'd0 || a_hit !== 1'b0 || a_cnt !== 16'd2) begin
            $display("FAIL clear_vs_bit got rem=%0d hit=%0b cnt=%0d exp rem=0 hit=0 cnt=2", a_rem, a_hit, a_cnt);
            failures++;
        end
        a_b = 1'b1; tick();
        a_b = 1'b0; tick();
        a_b = 1'b1; a_cclr = 1'b1;
        tick();
        a_cclr = 1'b0;
        checks++;
        if (a_rem !== 3'd0 || a_hit !== 1'b1 || a_cnt !== 16'd0) begin
            $display("FAIL cntclr_vs_hit got rem=%0d hit=%0b cnt=%0d exp rem=0 hit=1 cnt=0", a_rem, a_hit, a_cnt);
            failures++;
        end
        a_b = 1'b0; tick();
        a_v = 1'b0;
        checks++;
        if (a_cnt !== 16'd1) begin
            $display("FAIL count_resume got cnt=%0d exp cnt=1", a_cnt);
            failures++;
        end
    endtask

    task automatic test_zero();
        z_v = 1'b1; z_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (z0_hit !== 1'b0 || z0_cnt !== 16'd0 || z1_hit !== 1'b1 || z1_cnt !== 16'(i + 1)) begin
                $display("FAIL zero_bit%0d got z0 hit=%0b cnt=%0d z1 hit=%0b cnt=%0d exp z0 0 0 z1 1 %0d",
                         i, z0_hit, z0_cnt, z1_hit, z1_cnt, i + 1);
                failures++;
            end
        end
        z_b = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        z_v = 1'b0;
        checks++;
        if (z0_hit !== 1'b1 || z1_hit !== 1'b1 || z0_cnt !== 16'd1 || z1_cnt !== 16'd5 || z0_rem !== 3'd0) begin
            $display("FAIL zero_seven got z0 hit=%0b cnt=%0d z1 hit=%0b cnt=%0d exp hit 1 1 cnt 1 5",
                     z0_hit, z0_cnt, z1_hit, z1_cnt);
            failures++;
        end
    endtask

    task automatic test_saturate();
        logic       bits    [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [1:0] exp_cnt [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        logic       exp_sat [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            s_v = 1'b1; s_b = bits[i];
            tick();
            checks++;
            if (s_cnt !== exp_cnt[i] || s_sat !== exp_sat[i]) begin
                $display("FAIL sat_step%0d got cnt=%0d sat=%0b exp cnt=%0d sat=%0b",
                         i, s_cnt, s_sat, exp_cnt[i], exp_sat[i]);
                failures++;
            end
        end
        s_v = 1'b0; s_cclr = 1'b1;
        tick();
        s_cclr = 1'b0;
        checks++;
        if (s_cnt !== 2'd0 || s_sat !== 1'b0 || s_rem !== 2'd0 || s_hit !== 1'b1) begin
            $display("FAIL sat_clear got cnt=%0d sat=%0b rem=%0d hit=%0b exp 0 0 0 1", s_cnt, s_sat, s_rem, s_hit);
            failures++;
        end
        s_v = 1'b1; s_b = 1'b0;
        tick();
        s_v = 1'b0;
        checks++;
        if (s_cnt !== 2'd1 || s_sat !== 1'b0) begin
            $display("FAIL sat_recount got cnt=%0d sat=%0b exp cnt=1 sat=0", s_cnt, s_sat);
            failures++;
        end
    endtask

    task automatic test_multi();
        m_v = 4'b0011; m_b = 4'b0011;
        tick();
        checks++;
        if (m_rem !== 4'b0011 || m_hit !== 4'b0000) begin
            $display("FAIL multi_first got rem=%b hit=%b exp rem=0011 hit=0000", m_rem, m_hit);
            failures++;
        end
        m_b = 4'b0010;
        tick();
        m_v = 4'b0000;
        checks++;
        if (m_rem !== 4'b0010 || m_hit !== 4'b0001) begin
            $display("FAIL multi_second got rem=%b hit=%b exp rem=0010 hit=0001", m_rem, m_hit);
            failures++;
        end
        checks++;
        if (m_cnt !== {16'd0, 16'd0, 16'd0, 16'd1}) begin
            $display("FAIL multi_count got cnt=%h exp 0000000000000001", m_cnt);
            failures++;
        end
    endtask

    task automatic test_reset_mid();
        m_v = 4'b0011; m_b = 4'b0001;
        rst_n = 1'b0;
        tick();
        checks++;
        if (m_hit !== 4'b0 || m_rem !== 4'b0 || m_cnt !== 64'd0 || m_sat !== 4'b0) begin
            $display("FAIL reset_mid got hit=%b rem=%b cnt=%h sat=%b exp all 0", m_hit, m_rem, m_cnt, m_sat);
            failures++;
        end
        checks++;
        if (a_cnt !== 16'd0 || a_hit !== 1'b0 || z1_cnt !== 16'd0) begin
            $display("FAIL reset_mid_other got a_cnt=%0d a_hit=%0b z1_cnt=%0d exp 0 0 0", a_cnt, a_hit, z1_cnt);
            failures++;
        end
        m_v = 4'b0000;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_simultaneous();
        test_zero();
        test_saturate();
        test_multi();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mod_n_stream_detector.md
# mod_n_stream_detector

Multi-channel, parametrised divisibility detector for MSB-first serial bit streams. Each channel accumulates n = (n << 1) | bit on every accepted bit, tracks n mod DIVISOR, and flags when the accumulated value is divisible. It also counts divisible events per channel with a saturating counter. It sits alongside the single-channel divide-by-5 detector in the sample-design set and generalises it in divisor, channel count, flow control, zero handling and event statistics.

## Interface
- DIVISOR, default 5: modulus; legal range 2..255.
- CHANNELS, default 4: number of independent streams, minimum 1.
- CNT_W, default 16: width of each per-channel hit counter, minimum 1.
- ZERO_HIT, default 0: 0 means a value of 0 never flags; 1 means a value of 0 flags once at least one bit has been accepted.
- Derived: REM_W = max(1, $clog2(DIVISOR)).
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  CHANNELS  per-channel bit strobe; bit c accepted when high.
- in_bit  in  CHANNELS  per-channel data bit; sampled only when the matching in_valid is high.
- in_clear  in  CHANNELS  per-channel stream restart (n := 0).
- cnt_clr  in  CHANNELS  per-channel hit counter and saturation clear.
- div_hit  out  CHANNELS  registered; channel value currently divisible and qualified.
- remainder  out  CHANNELS*REM_W  registered n mod DIVISOR; channel c at [c*REM_W +: REM_W].
- hit_count  out  CHANNELS*CNT_W  registered divisible-event count; channel c at [c*CNT_W +: CNT_W].
- cnt_sat  out  CHANNELS  sticky; the channel counter has reached 2^CNT_W-1.

## Operation
- Per-channel state: rem (REM_W bits), qual (1 bit), cnt (CNT_W bits), sat (1 bit). Channels are fully independent; there is no shared state.
- Remainder update on an accepted bit: t = 2*rem + bit, computed at REM_W+1 bits. Then rem_next = (t >= DIVISOR) ? t - DIVISOR : t. rem < DIVISOR always holds, so a single conditional subtract is sufficient. No lookup table is used.
- qual_next on an accepted bit:
  - ZERO_HIT=0: qual | bit (set by the first accepted 1).
  - ZERO_HIT=1: 1 (set by any accepted bit).
- div_hit = (rem == 0) && qual. This is a Moore output taken from registered state only.
- Hit event: an accepted bit where rem_next == 0 and qual_next == 1. Each event increments cnt by 1. Back-to-back events each count, including a run of accepted 0s while rem == 0.
- Counter saturation: cnt holds at 2^CNT_W-1 and does not wrap. sat is set in the same edge that cnt reaches the maximum, and stays set until cnt_clr or reset.
- When in_valid is low, rem, qual, div_hit and cnt hold.
- in_clear: rem := 0 and qual := 0. cnt and sat are unaffected.
- cnt_clr: cnt := 0 and sat := 0. rem and qual are unaffected.
- Priority per channel, highest first:
  1. rst_n low.
  2. in_clear. Any bit presented in the same cycle is discarded and not counted.
  3. Accepted bit.
- Counter priority: cnt_clr with a simultaneous hit event gives cnt = 0 and sat = 0; that event is lost.
- Any rem value >= DIVISOR is unreachable. The implementation adds an assertion that rem < DIVISOR on every edge when out of reset.

## Timing
- Reset values on the first edge with rst_n low: div_hit = 0, remainder = 0, hit_count = 0, cnt_sat = 0, qual = 0, for all channels.
- Reset mid-stream discards accumulated state. Bits presented while rst_n is low are ignored.
- Latency: a bit accepted at edge k updates remainder, div_hit and hit_count at edge k (visible in cycle k+1). There are no combinational input-to-output paths.
- in_clear or cnt_clr asserted at edge k takes effect at edge k.
- Throughput: one bit per channel per cycle; no backpressure.

## Test plan
- DIVISOR=5, one channel, bits 1,0,1 back-to-back:
  - remainder sequence 1, 2, 0.
  - div_hit rises the cycle after the third bit.
  - hit_count = 1.
- DIVISOR=5, bits 1,0 with in_valid low for 3 cycles, then bit 1:
  - remainder holds at 2 during the gap.
  - ends at remainder 0, div_hit = 1.
  - then bit 0: remainder stays 0, hit_count = 2.
- Zero handling, DIVISOR=7, four accepted 0 bits:
  - ZERO_HIT=0: div_hit stays 0 and hit_count stays 0.
  - ZERO_HIT=1: div_hit = 1 after the first bit and hit_count = 4.
  - then bits 1,1,1 (value 7) in either mode: div_hit = 1.
- CNT_W=2, DIVISOR=3, stream 1,1 followed by five 0 bits:
  - hit_count goes 1, 2, 3, 3...; cnt_sat is set on reaching 3.
  - cnt_clr then gives hit_count = 0 and cnt_sat = 0.
- Simultaneous events:
  - in_clear with in_valid=1, bit=1 gives remainder = 0, div_hit = 0, count unchanged.
  - cnt_clr together with a hit event gives hit_count = 0.
- CHANNELS=4, DIVISOR=2:
  - Drive channel 0 = 1,0 (value 2), channel 1 = 1,1 (value 3), channels 2 and 3 idle.
  - Expected div_hit = 4'b0001; remainder fields {0,0,1,0}, listed as channels 3,2,1,0.
  - Assert rst_n low mid-stream: all outputs are 0 the next cycle.
